io_pwr_seq: RTL

Power-up/power-down sequencer for the IO pad ring that gates the supply cells, including the VPW/VDDIO/VDD power pads.
- Consumes asynchronous supply-good flags from the ring's level detectors.
- Releases pad retention, then output enables, in a fixed order with programmable spacing.
- Forces the ring back into retention the moment a supply drops.
- Sits between the pad ring's supply detectors and the core's IO control logic.

---
 rtl/io_pwr_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/io_pwr_seq.sv
// IO pad-ring power sequencer: debounces the supply-good flags, then releases
// retention and output enables in order, and drops back to retention on supply loss.
module io_pwr_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYC     = 64,
  parameter int unsigned RET_DLY     = 16,
  parameter int unsigned OE_DLY      = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddio_ok,
  input  logic       vdd_ok,
  input  logic       force_off,
  input  logic       fault_clr,
  output logic       pad_ret,
  output logic       pad_oe_en,
  output logic       io_ready,
  output logic       fault_sticky,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_RET_REL  = 3'd2;
  localparam logic [2:0] ST_OE_EN    = 3'd3;
  localparam logic [2:0] ST_READY    = 3'd4;
  localparam logic [2:0] ST_SHUTDOWN = 3'd5;
  localparam logic [2:0] ST_FAULT    = 3'd6;

  localparam logic [CNT_W-1:0] DEB_LD = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] RET_LD = CNT_W'(RET_DLY - 1);
  localparam logic [CNT_W-1:0] OE_LD  = CNT_W'(OE_DLY - 1);

  logic [SYNC_STAGES-1:0] vddio_sync_q, vddio_sync_d;
  logic [SYNC_STAGES-1:0] vdd_sync_q, vdd_sync_d;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pad_ret_q, pad_ret_d;
  logic                   pad_oe_en_q, pad_oe_en_d;
  logic                   io_ready_q, io_ready_d;
  logic                   fault_sticky_q, fault_sticky_d;
  logic                   ok;
  logic                   cnt_zero;

  always_comb begin
    vddio_sync_d = {vddio_sync_q[SYNC_STAGES-2:0], vddio_ok};
    vdd_sync_d   = {vdd_sync_q[SYNC_STAGES-2:0], vdd_ok};
  end

  assign ok       = vddio_sync_q[SYNC_STAGES-1] & vdd_sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  // Supply loss is tested first in every powered state so it wins over
  // force_off and over counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (ok && !force_off) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = DEB_LD;
        end
      end
      ST_DEBOUNCE: begin
        if (!ok || force_off) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = ST_RET_REL;
          cnt_d   = RET_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RET_REL: begin
        if (!ok) begin
          state_d = ST_FAULT;
          cnt_d   = RET_LD;
        end else if (force_off) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = ST_OE_EN;
          cnt_d   = OE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OE_EN: begin
        if (!ok) begin
          state_d = ST_FAULT;
          cnt_d   = RET_LD;
        end else if (force_off) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = OE_LD;
        end else if (cnt_zero) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READY: begin
        if (!ok) begin
          state_d = ST_FAULT;
          cnt_d   = RET_LD;
        end else if (force_off) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = OE_LD;
        end
      end
      ST_SHUTDOWN: begin
        if (!ok) begin
          state_d = ST_FAULT;
          cnt_d   = RET_LD;
        end else if (cnt_zero) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FAULT: begin
        if (cnt_zero) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as state_o.
  always_comb begin
    pad_ret_d   = 1'b1;
    pad_oe_en_d = 1'b0;
    io_ready_d  = 1'b0;
    case (state_d)
      ST_RET_REL, ST_SHUTDOWN: pad_ret_d = 1'b0;
      ST_OE_EN: begin
        pad_ret_d   = 1'b0;
        pad_oe_en_d = 1'b1;
      end
      ST_READY: begin
        pad_ret_d   = 1'b0;
        pad_oe_en_d = 1'b1;
        io_ready_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fault_sticky_d = fault_sticky_q;
    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      fault_sticky_d = 1'b1;
    end else if (fault_clr) begin
      fault_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vddio_sync_q   <= '0;
      vdd_sync_q     <= '0;
      state_q        <= ST_OFF;
      cnt_q          <= '0;
      pad_ret_q      <= 1'b1;
      pad_oe_en_q    <= 1'b0;
      io_ready_q     <= 1'b0;
      fault_sticky_q <= 1'b0;
    end else begin
      vddio_sync_q   <= vddio_sync_d;
      vdd_sync_q     <= vdd_sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pad_ret_q      <= pad_ret_d;
      pad_oe_en_q    <= pad_oe_en_d;
      io_ready_q     <= io_ready_d;
      fault_sticky_q <= fault_sticky_d;
    end
  end

  assign pad_ret      = pad_ret_q;
  assign pad_oe_en    = pad_oe_en_q;
  assign io_ready     = io_ready_q;
  assign fault_sticky = fault_sticky_q;
  assign state_o      = state_q;

endmodule
